mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, memory access cycles per word (legal 1..15).
REQ-002 SHALL have parameter WORD_SIZE, default 16, data/address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_req  input  1  instruction-side read request, held until i_ack.
REQ-006 SHALL have port i_addr  input  WORD_SIZE  instruction-side word address.
REQ-007 SHALL have port d_req  input  1  data-side request, held until d_ack.
REQ-008 SHALL have port d_we  input  1  data-side write (1) / read (0).
REQ-009 SHALL have port d_addr  input  WORD_SIZE  data-side word address.
REQ-010 SHALL have port d_wdata  input  WORD_SIZE  data-side write data.
REQ-011 SHALL have port i_ack  output  1  one-cycle completion pulse, instruction side.
REQ-012 SHALL have port d_ack  output  1  one-cycle completion pulse, data side.
REQ-013 SHALL have port rdata  output  WORD_SIZE  read data, valid in the ack cycle.
REQ-014 SHALL have ports mem_read, mem_write  output  1 each  shared memory strobes.
REQ-015 SHALL have ports mem_addr, mem_wdata  output  WORD_SIZE each  shared memory address/data.
REQ-016 SHALL have port mem_rdata  input  WORD_SIZE  memory read data, valid in last access cycle.
REQ-017 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, ACCESS, RESP.
REQ-019 IDLE: on edge with any request, SHALL grant one requester, latch its addr/we/wdata and owner, load counter = LATENCY-1, go ACCESS; else stay IDLE.
REQ-020 ACCESS: SHALL drive latched mem_addr/mem_wdata and mem_read (read) or mem_write (write) every cycle; counter decrements each edge; at edge with counter==0 SHALL capture mem_rdata into rdata, go RESP.
REQ-021 RESP: SHALL pulse owner's ack for exactly one cycle, strobes low, then go IDLE; no grant is made in RESP.
REQ-022 Latency: request sampled at edge k SHALL yield ack high in cycle between edges k+LATENCY and k+LATENCY+1; back-to-back throughput one word per LATENCY+2 cycles.
REQ-023 Arbitration with both requests in IDLE: fixed priority, data side wins (see REQ-029 for alternative).
REQ-024 Requester deasserting req during ACCESS SHALL NOT abort; access completes and ack still pulses once.
REQ-025 Inputs changing during ACCESS SHALL NOT affect mem_addr/mem_wdata/direction (latched values only).
REQ-026 Never both i_ack and d_ack high; never mem_read and mem_write high together; strobes low outside ACCESS.
REQ-027 Write transaction: rdata content in RESP unspecified; d_ack still pulses.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, counter 0, all strobes/acks/busy 0, rdata/mem_addr/mem_wdata 0, priority pointer to instruction-last-served; an in-flight access is dropped with no ack.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN: defined -> on simultaneous requests grant the side not served last (pointer updated at each grant, reset favours data side first); undefined -> fixed data-side priority, no pointer logic.

Verification
REQ-030 LATENCY=4, i_req at edge 0, addr 0x0010, mem_rdata 0x1234 -> mem_read high cycles 0-3, i_ack high in cycle 4, rdata 0x1234, busy low cycle 5.
REQ-031 d_req write addr 0x0020 data 0xBEEF -> mem_write high 4 cycles with addr 0x0020/data 0xBEEF, single d_ack, mem_read never high.
REQ-032 i_req and d_req held together, macro undefined -> d served first, i granted in IDLE after RESP; i_ack 6 cycles after d_ack.
REQ-033 Same stimulus, ARB_ROUND_ROBIN_EN defined, both held continuously for 4 grants -> grant order D, I, D, I.
REQ-034 reset_n low in 2nd ACCESS cycle -> strobes drop immediately, no ack ever, next request after release completes normally.
REQ-035 i_addr changed 0x0010->0x0099 mid-ACCESS -> mem_addr stays 0x0010 through access.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter onto one fixed-latency memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed data-side priority.
module mem_arbiter #(
    parameter int LATENCY   = 4,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 i_ack,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] count;
    logic       owner_d;
    logic       we_q;
    logic       grant_d;
    logic       any_req;

    assign any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d set means the data side won the most recent grant
    logic last_d;

    always_comb begin
        grant_d = d_req & (~i_req | ~last_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_d <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (count == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= 4'd0;
            owner_d   <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d   <= grant_d;
                        we_q      <= grant_d & d_we;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        count     <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        rdata <= mem_rdata;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and acks decode straight from state so reset clears them without waiting for a clock
    assign mem_read  = (state == ACCESS) & ~we_q;
    assign mem_write = (state == ACCESS) & we_q;
    assign i_ack     = (state == RESP) & ~owner_d;
    assign d_ack     = (state == RESP) & owner_d;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        i_ack;
    logic        d_ack;
    logic [15:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.LATENCY(4), .WORD_SIZE(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .i_ack     (i_ack),
        .d_ack     (d_ack),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Status vectors below are {mem_read, mem_write, busy, i_ack, d_ack}
    task automatic test_reset;
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #2;
        total++;
        if ({mem_read, mem_write, busy, i_ack, d_ack} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_status got=%b exp=00000", {mem_read, mem_write, busy, i_ack, d_ack});
        end
        total++;
        if ({rdata, mem_addr, mem_wdata} !== 48'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {rdata, mem_addr, mem_wdata});
        end
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_read;
        mem_rdata = 16'hDEAD;
        i_addr = 16'h0010;
        i_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 3) mem_rdata = 16'h1234;
            if (c < 4) begin
                total++;
                if ({mem_read, mem_write, busy, i_ack, d_ack} !== 5'b10100 || mem_addr !== 16'h0010) begin
                    bad++;
                    $display("FAIL read_access c=%0d got=%b addr=%h exp=10100 addr=0010", c,
                             {mem_read, mem_write, busy, i_ack, d_ack}, mem_addr);
                end
            end else if (c == 4) begin
                total++;
                if ({mem_read, mem_write, busy, i_ack, d_ack} !== 5'b00110 || rdata !== 16'h1234) begin
                    bad++;
                    $display("FAIL read_resp got=%b rdata=%h exp=00110 rdata=1234",
                             {mem_read, mem_write, busy, i_ack, d_ack}, rdata);
                end
                i_req = 1'b0;
            end else begin
                total++;
                if ({mem_read, mem_write, busy, i_ack, d_ack} !== 5'b00000) begin
                    bad++;
                    $display("FAIL read_idle got=%b exp=00000", {mem_read, mem_write, busy, i_ack, d_ack});
                end
            end
        end
    endtask

    task automatic test_write;
        int acks = 0;
        int reads = 0;
        d_addr = 16'h0020;
        d_wdata = 16'hBEEF;
        d_we = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (d_ack) acks++;
            if (mem_read) reads++;
            if (c < 4) begin
                total++;
                if (mem_write !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'hBEEF) begin
                    bad++;
                    $display("FAIL write_access c=%0d got=%b/%h/%h exp=1/0020/beef", c,
                             mem_write, mem_addr, mem_wdata);
                end
            end
            if (c == 4) begin
                total++;
                if ({mem_write, d_ack, i_ack} !== 3'b010) begin
                    bad++;
                    $display("FAIL write_resp got=%b exp=010", {mem_write, d_ack, i_ack});
                end
                d_req = 1'b0;
                d_we = 1'b0;
            end
        end
        total++;
        if (acks !== 1 || reads !== 0) begin
            bad++;
            $display("FAIL write_counts got acks=%0d reads=%0d exp acks=1 reads=0", acks, reads);
        end
    endtask

    task automatic test_priority;
        int d_cyc = -1;
        int i_cyc = -1;
        int clash = 0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        mem_rdata = 16'h0A0A;
        i_addr = 16'h0040;
        d_addr = 16'h0050;
        d_we = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if ((d_ack && i_ack) || (mem_read && mem_write)) clash++;
            if (d_ack) begin
                d_cyc = c;
                d_req = 1'b0;
            end
            if (i_ack) begin
                i_cyc = c;
                i_req = 1'b0;
            end
        end
        total++;
        if (d_cyc !== 4 || i_cyc !== 10) begin
            bad++;
            $display("FAIL priority_order got d=%0d i=%0d exp d=4 i=10", d_cyc, i_cyc);
        end
        total++;
        if (clash !== 0) begin
            bad++;
            $display("FAIL exclusive_outputs got=%0d exp=0", clash);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got;
        logic [31:0] exp;
        int n = 0;
        got = "????";
`ifdef ARB_ROUND_ROBIN_EN
        exp = "DIDI";
`else
        exp = "DDDD";
`endif
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        i_req = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c < 80; c++) begin
            step();
            if (d_ack) begin
                got[8*(3-n) +: 8] = "D";
                n++;
            end else if (i_ack) begin
                got[8*(3-n) +: 8] = "I";
                n++;
            end
            if (n == 4) break;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL grant_sequence got=%s exp=%s", got, exp);
        end
    endtask

    task automatic test_reset_mid_access;
        int acks = 0;
        i_addr = 16'h0060;
        i_req = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        #1;
        total++;
        if ({mem_read, mem_write, busy, i_ack, d_ack} !== 5'b00000 || mem_addr !== 16'h0) begin
            bad++;
            $display("FAIL midreset_drop got=%b addr=%h exp=00000 addr=0000",
                     {mem_read, mem_write, busy, i_ack, d_ack}, mem_addr);
        end
        i_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (i_ack || d_ack) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL midreset_noack got=%0d exp=0", acks);
        end
        mem_rdata = 16'h5678;
        d_addr = 16'h0030;
        d_we = 1'b0;
        d_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) begin
                total++;
                if (mem_read !== 1'b1 || mem_addr !== 16'h0030) begin
                    bad++;
                    $display("FAIL postreset_access got=%b/%h exp=1/0030", mem_read, mem_addr);
                end
            end
        end
        total++;
        if (d_ack !== 1'b1 || rdata !== 16'h5678) begin
            bad++;
            $display("FAIL postreset_resp got=%b/%h exp=1/5678", d_ack, rdata);
        end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_input_hold;
        int ack_cnt = 0;
        mem_rdata = 16'h00C3;
        i_addr = 16'h0010;
        i_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 1) begin
                i_addr = 16'h0099;
                i_req = 1'b0;
                d_addr = 16'h0077;
                d_we = 1'b1;
                d_wdata = 16'hFFFF;
            end
            if (c < 4) begin
                total++;
                if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 16'h0010) begin
                    bad++;
                    $display("FAIL hold_access c=%0d got=%b/%h exp=10/0010", c, {mem_read, mem_write}, mem_addr);
                end
            end
            if (i_ack) ack_cnt++;
        end
        d_we = 1'b0;
        total++;
        if (ack_cnt !== 1) begin
            bad++;
            $display("FAIL hold_ack_count got=%0d exp=1", ack_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_back_to_back();
        test_reset_mid_access();
        test_input_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
